// File: rtl/kernel_param_buf_pkg.sv
`default_nettype none
// ============================================================================
// kernel_param_buf_pkg : shared encodings for the kernel parameter buffer
// Revision: 1.0
// ============================================================================
package kernel_param_buf_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_RUN   = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int BIAS_MSB = 79;
    localparam int BIAS_LSB = 72;
    localparam int W_MSB    = 71;

endpackage
`default_nettype wire

// File: rtl/kernel_param_buf_ram.sv
`default_nettype none
// ============================================================================
// kernel_param_ram : DEPTH x DW register array, sync write / async read
// Revision: 1.0
// ============================================================================
module kernel_param_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 80
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/kernel_param_buf.sv
`default_nettype none
// ============================================================================
// kernel_param_buf : captures bias+weight words per output channel and
//                    streams them to the convolution engine on RUN
// Revision: 1.0
// ============================================================================
module kernel_param_buf
    import kernel_param_buf_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int WW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_state,
    input  logic [1:0]        i_layer,
    input  logic [5:0]        i_ic,
    input  logic [5:0]        i_oc,
    input  logic              i_valid,
    input  logic [10*WW-1:0]  i_params,
    input  logic              i_params_valid,
    output logic [WW-1:0]     m_bias,
    output logic [9*WW-1:0]   m_weights,
    output logic [AW-1:0]     m_idx,
    output logic [1:0]        m_layer,
    output logic [5:0]        m_ic,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [AW:0]       o_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);

    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [AW-1:0]      wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [5:0]         oc_lat;
    logic [10*WW-1:0]   rd_data;

    logic cmd_load;
    logic cmd_run;
    logic cmd_clear;
    logic cmd_any;
    logic wr_en;
    logic wr_drop;
    logic oc_hit;
    logic load_beat;
    logic last_hs;

    kernel_param_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (10*WW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (i_params),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    // State register; busy/done are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= next_state;
            o_busy <= (next_state == S_RUN);
            o_done <= (next_state == S_DONE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_LOAD:  if (oc_hit) next_state = S_IDLE;
            S_RUN:   if (last_hs) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = state;
        endcase
        if (cmd_load) begin
            next_state = S_LOAD;
        end else if (cmd_run) begin
            next_state = (o_count != '0) ? S_RUN : S_DONE;
        end
        if (cmd_clear) begin
            next_state = S_IDLE;
        end
    end

    // Command decode and datapath strobes. An accepted command in the same
    // cycle as a data word takes priority and swallows the word silently.
    always_comb begin
        cmd_load  = 1'b0;
        cmd_run   = 1'b0;
        cmd_clear = 1'b0;
        if (i_valid) begin
            case (i_state)
                CMD_IDLE:  cmd_clear = 1'b0;
                CMD_LOAD:  cmd_load  = (state == S_IDLE) || (state == S_LOAD);
                CMD_RUN:   cmd_run   = (state == S_IDLE) || (state == S_LOAD);
                CMD_CLEAR: cmd_clear = 1'b1;
                default:   cmd_clear = 1'b0;
            endcase
        end
        cmd_any   = cmd_load || cmd_run || cmd_clear;
        wr_en     = i_params_valid && !cmd_any && (state == S_LOAD) && (o_count != FULL);
        wr_drop   = i_params_valid && !cmd_any && !wr_en;
        oc_hit    = wr_en && (oc_lat != 6'd0) && ((7'(o_count) + 7'd1) == 7'(oc_lat));
        load_beat = (state == S_RUN) && (!m_valid || (m_ready && !m_last));
        last_hs   = (state == S_RUN) && m_valid && m_ready && m_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            oc_lat     <= '0;
            m_layer    <= '0;
            m_ic       <= '0;
            m_bias     <= '0;
            m_weights  <= '0;
            m_idx      <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            o_overflow <= 1'b0;
        end else if (cmd_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (cmd_load) begin
                m_layer <= i_layer;
                m_ic    <= i_ic;
                oc_lat  <= i_oc;
                wr_ptr  <= '0;
                o_count <= '0;
            end
            if (cmd_run) begin
                rd_ptr <= '0;
            end
            if (wr_en) begin
                wr_ptr  <= wr_ptr + 1'b1;
                o_count <= o_count + CNT_ONE;
            end
            if (wr_drop) begin
                o_overflow <= 1'b1;
            end
            // Prefetch the next entry as soon as the current beat is taken.
            if (load_beat) begin
                m_valid   <= 1'b1;
                m_bias    <= rd_data[BIAS_MSB:BIAS_LSB];
                m_weights <= rd_data[W_MSB:0];
                m_idx     <= rd_ptr[AW-1:0];
                m_last    <= (rd_ptr == (o_count - CNT_ONE));
                rd_ptr    <= rd_ptr + CNT_ONE;
            end else if (last_hs) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kernel_param_buf.sv
`default_nettype none
// ============================================================================
// tb_kernel_param_buf : randomized self-checking bench with a behavioural model
// Revision: 1.0
// ============================================================================
module tb_kernel_param_buf;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int WW    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        i_state = 2'd0;
    logic [1:0]        i_layer = 2'd0;
    logic [5:0]        i_ic = 6'd0;
    logic [5:0]        i_oc = 6'd0;
    logic              i_valid = 1'b0;
    logic [79:0]       i_params = '0;
    logic              i_params_valid = 1'b0;
    logic [WW-1:0]     m_bias;
    logic [9*WW-1:0]   m_weights;
    logic [AW-1:0]     m_idx;
    logic [1:0]        m_layer;
    logic [5:0]        m_ic;
    logic              m_valid;
    logic              m_last;
    logic              m_ready = 1'b0;
    logic [AW:0]       o_count;
    logic              o_busy;
    logic              o_done;
    logic              o_overflow;

    kernel_param_buf #(.DEPTH(DEPTH), .AW(AW), .WW(WW)) dut (
        .clk(clk), .rst(rst), .i_state(i_state), .i_layer(i_layer), .i_ic(i_ic),
        .i_oc(i_oc), .i_valid(i_valid), .i_params(i_params),
        .i_params_valid(i_params_valid), .m_bias(m_bias), .m_weights(m_weights),
        .m_idx(m_idx), .m_layer(m_layer), .m_ic(m_ic), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready), .o_count(o_count), .o_busy(o_busy),
        .o_done(o_done), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a list of stored words plus load/overflow bookkeeping.
    logic [79:0] mmem [DEPTH];
    int          mcount   = 0;
    bit          mover    = 0;
    bit          mloading = 0;
    int          moc      = 0;
    logic [1:0]  mlayer   = 0;
    logic [5:0]  mic      = 0;

    task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] pat(input int k);
        logic [79:0] w;
        for (int j = 0; j < 10; j++) w[j*8 +: 8] = 8'((k << 4) | j);
        return w;
    endfunction

    function automatic logic [79:0] rnd_word();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    task automatic model_write(input logic [79:0] w);
        if (mloading && mcount < DEPTH) begin
            mmem[mcount] = w;
            mcount++;
            if (moc != 0 && mcount == moc) mloading = 0;
        end else begin
            mover = 1;
        end
    endtask

    task automatic model_reset();
        mcount = 0; mover = 0; mloading = 0; moc = 0; mlayer = 0; mic = 0;
    endtask

    task automatic send_cmd(input logic [1:0] cmd, input logic [1:0] layer,
                            input logic [5:0] ic, input logic [5:0] oc);
        @(posedge clk); #1;
        i_valid = 1'b1; i_state = cmd; i_layer = layer; i_ic = ic; i_oc = oc;
        @(posedge clk); #1;
        i_valid = 1'b0;
        case (cmd)
            2'd1: begin mloading = 1; mcount = 0; moc = int'(oc); mlayer = layer; mic = ic; end
            2'd2: mloading = 0;
            2'd3: begin mloading = 0; mcount = 0; mover = 0; end
            default: ;
        endcase
    endtask

    task automatic write_word(input logic [79:0] w);
        @(posedge clk); #1;
        i_params = w; i_params_valid = 1'b1;
        @(posedge clk); #1;
        i_params_valid = 1'b0;
        model_write(w);
    endtask

    task automatic check_status(input string pfx);
        check_val({pfx, "_count"}, 96'(o_count), 96'(mcount));
        check_val({pfx, "_ovf"}, 96'(o_overflow), 96'(mover));
        check_val({pfx, "_layer"}, 96'(m_layer), 96'(mlayer));
        check_val({pfx, "_ic"}, 96'(m_ic), 96'(mic));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_mvalid"}, 96'({m_valid, m_last}), 96'(0));
        check_val({pfx, "_mdata"}, 96'({m_bias, m_weights}), 96'(0));
        check_val({pfx, "_midx"}, 96'(m_idx), 96'(0));
        check_val({pfx, "_ctx"}, 96'({m_layer, m_ic}), 96'(0));
        check_val({pfx, "_count"}, 96'(o_count), 96'(0));
        check_val({pfx, "_flags"}, 96'({o_busy, o_done, o_overflow}), 96'(0));
    endtask

    // mode 0: always ready, 1: toggling 1010..., 2: random backpressure
    task automatic run_stream(input string pfx, input int mode);
        int n = mcount;
        int k = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        int acc_cyc = -1;
        logic [79:0] e;
        send_cmd(2'd2, 2'd0, 6'd0, 6'd0);
        m_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                if (k < n) begin
                    e = mmem[k];
                    check_val({pfx, "_idx"}, 96'(m_idx), 96'(k));
                    check_val({pfx, "_bias"}, 96'(m_bias), 96'(e[79:72]));
                    check_val({pfx, "_wts"}, 96'(m_weights), 96'(e[71:0]));
                    check_val({pfx, "_last"}, 96'(m_last), 96'(k == n - 1));
                    check_val({pfx, "_busy"}, 96'(o_busy), 96'(1));
                end else begin
                    check_val({pfx, "_extra_beat"}, 96'(1), 96'(0));
                end
                if (m_ready) begin
                    k++;
                    if (k == n) acc_cyc = cyc;
                end
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                check_val({pfx, "_busy_at_done"}, 96'(o_busy), 96'(0));
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            @(posedge clk); #1;
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
        check_val({pfx, "_beats"}, 96'(k), 96'(n));
        check_val({pfx, "_done_cnt"}, 96'(done_cnt), 96'(1));
        if (n > 0) check_val({pfx, "_done_lat"}, 96'(done_cyc), 96'(acc_cyc + 1));
        check_status({pfx, "_post"});
        m_ready = 1'b0;
    endtask

    int done_seen;
    int valid_seen;
    int oc_r;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Four patterned kernels, streamed with and without backpressure.
        send_cmd(2'd1, 2'd1, 6'd5, 6'd4);
        for (int i = 0; i < 4; i++) write_word(pat(i + 1));
        @(negedge clk);
        check_status("load4");
        run_stream("run4", 0);
        run_stream("run4_toggle", 1);

        // Unbounded load fills the buffer, extra word overflows.
        send_cmd(2'd1, 2'd2, 6'd9, 6'd0);
        for (int i = 0; i < DEPTH + 1; i++) write_word(rnd_word());
        @(negedge clk);
        check_status("fill");
        run_stream("run_full", 2);

        // Empty buffer: RUN yields only the done pulse.
        send_cmd(2'd3, 2'd0, 6'd0, 6'd0);
        @(negedge clk);
        check_status("clear");
        run_stream("run_empty", 0);

        // LOAD and a data word in the same cycle: the word is discarded.
        @(posedge clk); #1;
        i_valid = 1'b1; i_state = 2'd1; i_layer = 2'd3; i_ic = 6'd17; i_oc = 6'd4;
        i_params = rnd_word(); i_params_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_params_valid = 1'b0;
        mloading = 1; mcount = 0; moc = 4; mlayer = 2'd3; mic = 6'd17;
        @(negedge clk);
        check_status("load_collide");
        for (int i = 0; i < 4; i++) write_word(rnd_word());
        write_word(rnd_word());
        @(negedge clk);
        check_status("stray_write");

        // CLEAR while beat 2 of 4 is presented.
        send_cmd(2'd2, 2'd0, 6'd0, 6'd0);
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_val("abort_pre_valid", 96'(m_valid), 96'(1));
        check_val("abort_pre_idx", 96'(m_idx), 96'(2));
        i_valid = 1'b1; i_state = 2'd3;
        @(posedge clk); #1;
        i_valid = 1'b0;
        mloading = 0; mcount = 0; mover = 0;
        done_seen = 0;
        valid_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_done) done_seen++;
            if (m_valid) valid_seen++;
        end
        check_val("abort_valid", 96'(valid_seen), 96'(0));
        check_val("abort_done", 96'(done_seen), 96'(0));
        check_val("abort_busy", 96'(o_busy), 96'(0));
        check_status("abort");
        m_ready = 1'b0;

        // Reset in the middle of a stream, then a fresh two-entry stream.
        send_cmd(2'd1, 2'd1, 6'd3, 6'd3);
        for (int i = 0; i < 3; i++) write_word(rnd_word());
        send_cmd(2'd2, 2'd0, 6'd0, 6'd0);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("midrst");
        send_cmd(2'd1, 2'd2, 6'd33, 6'd2);
        for (int i = 0; i < 2; i++) write_word(rnd_word());
        @(negedge clk);
        check_status("load2");
        run_stream("run2", 0);

        // Random loads and streams under random backpressure.
        for (int t = 0; t < 8; t++) begin
            oc_r = $urandom_range(1, 9);
            send_cmd(2'd1, 2'($urandom), 6'($urandom), 6'(oc_r));
            for (int i = 0; i < oc_r; i++) begin
                if ($urandom_range(0, 1) == 1) @(posedge clk);
                write_word(rnd_word());
            end
            @(negedge clk);
            check_status("rnd_load");
            run_stream("rnd_run", 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
